// File: rtl/contador_pkg.sv
// Shared definitions for the sequence-counter monitor: the fixed count table,
// FSM state codes and index arithmetic.
package contador_pkg;

    localparam int SEQ_LEN = 10;

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    typedef struct packed {
        logic       found;
        logic [3:0] index;
    } lookup_t;

    // Descending count with the 1 and 0 entries swapped.
    function automatic logic [3:0] seq_at(input logic [3:0] i);
        logic [3:0] v;
        case (i)
            4'd0:    v = 4'd9;
            4'd1:    v = 4'd8;
            4'd2:    v = 4'd7;
            4'd3:    v = 4'd6;
            4'd4:    v = 4'd5;
            4'd5:    v = 4'd4;
            4'd6:    v = 4'd3;
            4'd7:    v = 4'd2;
            4'd8:    v = 4'd0;
            4'd9:    v = 4'd1;
            default: v = 4'd0;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] idx_inc(input logic [3:0] i);
        return (i >= 4'(SEQ_LEN - 1)) ? 4'd0 : i + 4'd1;
    endfunction

endpackage

// File: rtl/contador_if.sv
// Bus between a sequence counter (master) and its monitor (slave).
interface contador_if #(
    parameter int W    = 4,
    parameter int ERRW = 8
) ();
    logic            E;
    logic [W-1:0]    Q_in;
    logic            LOCK;
    logic            ERR;
    logic [3:0]      IDX;
    logic [W-1:0]    NEXT;
    logic [ERRW-1:0] ERRCNT;

    modport master (output E, Q_in, input LOCK, ERR, IDX, NEXT, ERRCNT);
    modport slave  (input E, Q_in, output LOCK, ERR, IDX, NEXT, ERRCNT);
endinterface

// File: rtl/contador_tabla.sv
// Combinational sequence table: value-to-index search and index-to-value read.
module contador_tabla
    import contador_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] value,
    output lookup_t      hit,
    input  logic [3:0]   at,
    output logic [W-1:0] entry
);

    // Table entries are distinct, so at most one index can match.
    always_comb begin
        hit = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (value == W'(seq_at(4'(i)))) begin
                hit.found = 1'b1;
                hit.index = 4'(i);
            end
        end
    end

    assign entry = W'(seq_at(at));

endmodule

// File: rtl/contador_monitor.sv
// Monitors a 4-bit sequence counter: acquires lock on the fixed table,
// tracks position, flags and counts out-of-sequence samples.
module contador_monitor
    import contador_pkg::*;
#(
    parameter int W      = 4,
    parameter int LOCK_N = 2,
    parameter int MISS_N = 3,
    parameter int ERRW   = 8
) (
    input  logic     C,
    input  logic     nR,
    contador_if.slave bus
);

    localparam int MCW = $clog2(LOCK_N + 1);
    localparam int MSW = $clog2(MISS_N + 1);

    logic [1:0]      state, state_n;
    logic [3:0]      idx, idx_n;
    logic [MCW-1:0]  match_cnt, match_n;
    logic [MSW-1:0]  miss_cnt, miss_n;
    logic [ERRW-1:0] errcnt, errcnt_n;
    logic            err_n;
    logic            lock;
    logic            err;
    logic [W-1:0]    next_val;
    logic [W-1:0]    entry;
    lookup_t         hit;
    logic            mismatch;

    contador_tabla #(.W(W)) u_tabla (
        .value (bus.Q_in),
        .hit   (hit),
        .at    (idx_inc(idx_n)),
        .entry (entry)
    );

    // The registered NEXT is exactly the value expected from the current sample.
    assign mismatch = (bus.Q_in != next_val);

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        match_n  = match_cnt;
        miss_n   = miss_cnt;
        errcnt_n = errcnt;
        err_n    = 1'b0;
        if (bus.E) begin
            case (state)
                SEARCH: begin
                    if (hit.found) begin
                        state_n = CHECK;
                        idx_n   = hit.index;
                        match_n = '0;
                    end
                end
                CHECK: begin
                    if (!mismatch) begin
                        idx_n   = idx_inc(idx);
                        match_n = match_cnt + MCW'(1);
                        if (match_cnt == MCW'(LOCK_N - 1)) begin
                            state_n = LOCKED;
                            miss_n  = '0;
                        end
                    end else if (hit.found) begin
                        idx_n   = hit.index;
                        match_n = '0;
                    end else begin
                        state_n = SEARCH;
                        idx_n   = 4'd0;
                        match_n = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: position advances even on a bad sample.
                    idx_n = idx_inc(idx);
                    if (!mismatch) begin
                        miss_n = '0;
                    end else begin
                        err_n  = 1'b1;
                        miss_n = miss_cnt + MSW'(1);
                        if (errcnt != {ERRW{1'b1}}) begin
                            errcnt_n = errcnt + ERRW'(1);
                        end
                        if (miss_cnt == MSW'(MISS_N - 1)) begin
                            state_n = SEARCH;
                            idx_n   = 4'd0;
                            miss_n  = '0;
                            match_n = '0;
                        end
                    end
                end
                default: begin
                    state_n = SEARCH;
                    idx_n   = 4'd0;
                    match_n = '0;
                    miss_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge C) begin
        if (!nR) begin
            state     <= SEARCH;
            idx       <= 4'd0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            errcnt    <= '0;
            err       <= 1'b0;
            lock      <= 1'b0;
            next_val  <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            match_cnt <= match_n;
            miss_cnt  <= miss_n;
            errcnt    <= errcnt_n;
            err       <= err_n;
            lock      <= (state_n == LOCKED);
            next_val  <= (state_n == SEARCH) ? '0 : entry;
        end
    end

    assign bus.LOCK   = lock;
    assign bus.ERR    = err;
    assign bus.IDX    = idx;
    assign bus.NEXT   = next_val;
    assign bus.ERRCNT = errcnt;

endmodule

// File: tb/tb_contador_monitor.sv
// Self-checking bench for contador_monitor: directed plan plus random traffic,
// compared against a table-driven behavioural model.
module tb_contador_monitor;

    logic C = 1'b0;
    logic nR;

    always #5 C = ~C;

    contador_if #(.W(4), .ERRW(8)) bus_a ();
    contador_if #(.W(4), .ERRW(8)) bus_b ();

    contador_monitor #(.W(4), .LOCK_N(2), .MISS_N(3), .ERRW(8)) dut_a (
        .C   (C),
        .nR  (nR),
        .bus (bus_a.slave)
    );

    contador_monitor #(.W(4), .LOCK_N(2), .MISS_N(300), .ERRW(8)) dut_b (
        .C   (C),
        .nR  (nR),
        .bus (bus_b.slave)
    );

    typedef struct packed {
        int pos;
        int run;
        int miss;
        bit locked;
        int errs;
        bit err;
        int missn;
    } model_t;

    int     seq_tab [10] = '{9, 8, 7, 6, 5, 4, 3, 2, 0, 1};
    model_t ma;
    model_t mb;
    int     compared   = 0;
    int     mismatched = 0;

    function automatic int find_pos(int q);
        for (int i = 0; i < 10; i++) begin
            if (seq_tab[i] == q) return i;
        end
        return -1;
    endfunction

    function automatic int want_next(model_t m);
        return (m.pos < 0) ? 0 : seq_tab[(m.pos + 1) % 10];
    endfunction

    function automatic model_t step(model_t m, bit nr, bit e, int q);
        model_t r = m;
        int f;
        r.err = 1'b0;
        if (!nr) begin
            r.pos = -1; r.run = 0; r.miss = 0; r.locked = 1'b0; r.errs = 0;
        end else if (e) begin
            f = find_pos(q);
            if (m.pos < 0) begin
                if (f >= 0) begin
                    r.pos = f; r.run = 0;
                end
            end else if (!m.locked) begin
                if (q == want_next(m)) begin
                    r.pos = (m.pos + 1) % 10;
                    r.run = m.run + 1;
                    if (r.run == 2) begin
                        r.locked = 1'b1; r.miss = 0;
                    end
                end else begin
                    r.pos = f; r.run = 0;
                end
            end else begin
                r.pos = (m.pos + 1) % 10;
                if (q == want_next(m)) begin
                    r.miss = 0;
                end else begin
                    r.err  = 1'b1;
                    r.errs = m.errs + 1;
                    r.miss = m.miss + 1;
                    if (r.miss == m.missn) begin
                        r.locked = 1'b0; r.pos = -1; r.run = 0; r.miss = 0;
                    end
                end
            end
        end
        return r;
    endfunction

    task automatic checkOne(string tag, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(bit nr, bit ea, int qa, bit eb, int qb);
        nR         = nr;
        bus_a.E    = ea;
        bus_a.Q_in = 4'(qa);
        bus_b.E    = eb;
        bus_b.Q_in = 4'(qb);
        @(posedge C);
        ma = step(ma, nr, ea, qa);
        mb = step(mb, nr, eb, qb);
        #1;
    endtask

    task automatic checkOutput();
        checkOne("a.LOCK",   32'(bus_a.LOCK),   32'(ma.locked));
        checkOne("a.ERR",    32'(bus_a.ERR),    32'(ma.err));
        checkOne("a.IDX",    32'(bus_a.IDX),    32'((ma.pos < 0) ? 0 : ma.pos));
        checkOne("a.NEXT",   32'(bus_a.NEXT),   32'(want_next(ma)));
        checkOne("a.ERRCNT", 32'(bus_a.ERRCNT), 32'((ma.errs > 255) ? 255 : ma.errs));
        checkOne("b.LOCK",   32'(bus_b.LOCK),   32'(mb.locked));
        checkOne("b.ERR",    32'(bus_b.ERR),    32'(mb.err));
        checkOne("b.IDX",    32'(bus_b.IDX),    32'((mb.pos < 0) ? 0 : mb.pos));
        checkOne("b.NEXT",   32'(bus_b.NEXT),   32'(want_next(mb)));
        checkOne("b.ERRCNT", 32'(bus_b.ERRCNT), 32'((mb.errs > 255) ? 255 : mb.errs));
    endtask

    task automatic feedA(int q);
        applyStimulus(1'b1, 1'b1, q, 1'b0, 0);
        checkOutput();
    endtask

    initial begin
        int wrap_idx [5] = '{7, 8, 9, 0, 1};
        int wrap_val [5] = '{2, 0, 1, 9, 8};
        bit nr_r, ea_r, eb_r;
        int qa_r, qb_r;

        ma = '0; ma.pos = -1; ma.missn = 3;
        mb = '0; mb.pos = -1; mb.missn = 300;
        nR = 1'b0;
        bus_a.E = 1'b0; bus_a.Q_in = '0;
        bus_b.E = 1'b0; bus_b.Q_in = '0;

        // Reset with strobe high and a valid table value present.
        applyStimulus(1'b0, 1'b1, 9, 1'b1, 9);
        applyStimulus(1'b0, 1'b1, 9, 1'b1, 9);
        checkOutput();
        checkOne("rst.LOCK",   32'(bus_a.LOCK),   32'd0);
        checkOne("rst.IDX",    32'(bus_a.IDX),    32'd0);
        checkOne("rst.ERRCNT", 32'(bus_a.ERRCNT), 32'd0);

        // Acquire.
        feedA(7);
        checkOne("acq7.IDX",  32'(bus_a.IDX),  32'd2);
        checkOne("acq7.NEXT", 32'(bus_a.NEXT), 32'd6);
        checkOne("acq7.LOCK", 32'(bus_a.LOCK), 32'd0);
        feedA(6);
        checkOne("acq6.IDX",  32'(bus_a.IDX),  32'd3);
        feedA(5);
        checkOne("acq5.LOCK", 32'(bus_a.LOCK), 32'd1);
        checkOne("acq5.IDX",  32'(bus_a.IDX),  32'd4);
        checkOne("acq5.NEXT", 32'(bus_a.NEXT), 32'd4);

        // Wrap-around through the swapped 0/1 entries.
        feedA(4);
        feedA(3);
        for (int i = 0; i < 5; i++) begin
            feedA(wrap_val[i]);
            checkOne("wrap.IDX", 32'(bus_a.IDX), 32'(wrap_idx[i]));
            checkOne("wrap.ERR", 32'(bus_a.ERR), 32'd0);
        end

        // Single glitch while locked.
        feedA(7); feedA(6); feedA(5);
        feedA(12);
        checkOne("glitch.ERR",    32'(bus_a.ERR),    32'd1);
        checkOne("glitch.ERRCNT", 32'(bus_a.ERRCNT), 32'd1);
        checkOne("glitch.LOCK",   32'(bus_a.LOCK),   32'd1);
        checkOne("glitch.IDX",    32'(bus_a.IDX),    32'd5);
        feedA(3);
        checkOne("after.ERR", 32'(bus_a.ERR), 32'd0);
        checkOne("after.IDX", 32'(bus_a.IDX), 32'd6);

        // Loss of lock and reacquisition.
        for (int i = 0; i < 3; i++) begin
            feedA(15);
            checkOne("loss.ERR", 32'(bus_a.ERR), 32'd1);
        end
        checkOne("loss.LOCK",   32'(bus_a.LOCK),   32'd0);
        checkOne("loss.IDX",    32'(bus_a.IDX),    32'd0);
        checkOne("loss.ERRCNT", 32'(bus_a.ERRCNT), 32'd4);
        feedA(15);
        checkOne("search.ERR", 32'(bus_a.ERR), 32'd0);
        feedA(6); feedA(5); feedA(4);
        checkOne("relock.LOCK",   32'(bus_a.LOCK),   32'd1);
        checkOne("relock.ERRCNT", 32'(bus_a.ERRCNT), 32'd4);

        // Strobe low: everything holds.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, int'($urandom_range(15, 0)), 1'b0, int'($urandom_range(15, 0)));
            checkOutput();
            checkOne("gate.ERR", 32'(bus_a.ERR), 32'd0);
        end

        // Reset while locked.
        applyStimulus(1'b0, 1'b1, 2, 1'b1, 9);
        checkOutput();
        checkOne("rstlk.LOCK",   32'(bus_a.LOCK),   32'd0);
        checkOne("rstlk.ERRCNT", 32'(bus_a.ERRCNT), 32'd0);

        // Saturation on the instance with a very large miss threshold.
        applyStimulus(1'b1, 1'b0, 0, 1'b1, 9);
        applyStimulus(1'b1, 1'b0, 0, 1'b1, 8);
        applyStimulus(1'b1, 1'b0, 0, 1'b1, 7);
        checkOutput();
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1'b1, 1'b0, 0, 1'b1, 15);
            checkOutput();
        end
        checkOne("sat.ERRCNT", 32'(bus_b.ERRCNT), 32'd255);
        checkOne("sat.LOCK",   32'(bus_b.LOCK),   32'd1);

        // Random traffic biased toward in-sequence values, with rare resets.
        for (int i = 0; i < 400; i++) begin
            nr_r = ($urandom_range(39, 0) != 0);
            ea_r = ($urandom_range(3, 0) != 0);
            eb_r = ($urandom_range(3, 0) != 0);
            qa_r = ($urandom_range(9, 0) < 7 && ma.pos >= 0) ? want_next(ma) : int'($urandom_range(15, 0));
            qb_r = ($urandom_range(9, 0) < 7 && mb.pos >= 0) ? want_next(mb) : int'($urandom_range(15, 0));
            applyStimulus(nr_r, ea_r, qa_r, eb_r, qb_r);
            checkOutput();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
